// File: rtl/sdr_init_seq_if.sv
// SDRAM command-pin bundle driven by the init sequencer (master) and
// observed by the pad logic / downstream command mux (slave).
interface sdr_init_seq_if #(
  parameter int SDR_ADDR_W = 13,
  parameter int SDR_BA_W   = 2
);
  logic                  sdr_cke;
  logic                  sdr_cs_n;
  logic                  sdr_ras_n;
  logic                  sdr_cas_n;
  logic                  sdr_we_n;
  logic [SDR_BA_W-1:0]   sdr_ba;
  logic [SDR_ADDR_W-1:0] sdr_addr;

  modport master (
    output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr
  );

  modport slave (
    input sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr
  );
endinterface

// File: rtl/sdr_init_seq.sv
// SDRAM power-up init sequencer: NOP hold, PRECHARGE-ALL, 2x AUTO-REFRESH, LOAD MODE.
// Optional SDR_INIT_EXT_MODE_EN adds a LOAD EXT MODE (ba=1) after the mode-register wait.
module sdr_init_seq #(
  parameter int INIT_NOP_CYCLES = 500,
  parameter int SDR_ADDR_W      = 13,
  parameter int SDR_BA_W        = 2
) (
  input  logic                  sdram_clk,
  input  logic                  sdram_resetn,
  input  logic                  cfg_sdr_en,
  input  logic [SDR_ADDR_W-1:0] cfg_sdr_mode_reg,
`ifdef SDR_INIT_EXT_MODE_EN
  input  logic [SDR_ADDR_W-1:0] cfg_sdr_ext_mode_reg,
`endif
  input  logic [3:0]            cfg_sdr_trp_d,
  input  logic [3:0]            cfg_sdr_trcar_d,
  input  logic [3:0]            cfg_sdr_tmrd_d,
  input  logic                  cfg_init_req,
  sdr_init_seq_if.master        sdr,
  output logic                  init_done,
  output logic [3:0]            dbg_state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    NOP_WAIT  = 4'd1,
    PRE       = 4'd2,
    WAIT_TRP  = 4'd3,
    REF1      = 4'd4,
    WAIT_RFC1 = 4'd5,
    REF2      = 4'd6,
    WAIT_RFC2 = 4'd7,
    LMR       = 4'd8,
    WAIT_MRD  = 4'd9,
    LEMR      = 4'd10,
    WAIT_EMRD = 4'd11,
    DONE      = 4'd12
  } state_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;

  localparam int NOP_CNT_W = $clog2(INIT_NOP_CYCLES + 1);
  localparam logic [NOP_CNT_W-1:0] NOP_LAST =
    NOP_CNT_W'((INIT_NOP_CYCLES > 0) ? INIT_NOP_CYCLES - 1 : 0);

  state_t                state, state_nxt;
  logic [NOP_CNT_W-1:0]  nop_cnt, nop_nxt;
  logic [3:0]            wait_cnt, wait_nxt;

  logic                  cke_q, cke_nxt;
  logic [3:0]            cmd_q, cmd_nxt;
  logic [SDR_BA_W-1:0]   ba_q, ba_nxt;
  logic [SDR_ADDR_W-1:0] addr_q, addr_nxt;
  logic                  done_q, done_nxt;

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state    <= IDLE;
      nop_cnt  <= '0;
      wait_cnt <= '0;
      cke_q    <= 1'b0;
      cmd_q    <= CMD_DESEL;
      ba_q     <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      nop_cnt  <= nop_nxt;
      wait_cnt <= wait_nxt;
      cke_q    <= cke_nxt;
      cmd_q    <= cmd_nxt;
      ba_q     <= ba_nxt;
      addr_q   <= addr_nxt;
      done_q   <= done_nxt;
    end
  end

  // Gap of N cycles between commands means N-1 wait cycles; a cfg of 0 or 1
  // skips the wait state entirely, otherwise the wait counter loads N-2.
  always_comb begin
    state_nxt = state;
    nop_nxt   = nop_cnt;
    wait_nxt  = wait_cnt;
    case (state)
      IDLE: begin
        if (cfg_sdr_en) begin
          state_nxt = NOP_WAIT;
          nop_nxt   = '0;
        end
      end
      NOP_WAIT: begin
        if (nop_cnt >= NOP_LAST) state_nxt = PRE;
        else                     nop_nxt   = nop_cnt + 1'b1;
      end
      PRE: begin
        if (cfg_sdr_trp_d < 4'd2) state_nxt = REF1;
        else begin
          state_nxt = WAIT_TRP;
          wait_nxt  = cfg_sdr_trp_d - 4'd2;
        end
      end
      WAIT_TRP: begin
        if (wait_cnt == 4'd0) state_nxt = REF1;
        else                  wait_nxt  = wait_cnt - 4'd1;
      end
      REF1: begin
        if (cfg_sdr_trcar_d < 4'd2) state_nxt = REF2;
        else begin
          state_nxt = WAIT_RFC1;
          wait_nxt  = cfg_sdr_trcar_d - 4'd2;
        end
      end
      WAIT_RFC1: begin
        if (wait_cnt == 4'd0) state_nxt = REF2;
        else                  wait_nxt  = wait_cnt - 4'd1;
      end
      REF2: begin
        if (cfg_sdr_trcar_d < 4'd2) state_nxt = LMR;
        else begin
          state_nxt = WAIT_RFC2;
          wait_nxt  = cfg_sdr_trcar_d - 4'd2;
        end
      end
      WAIT_RFC2: begin
        if (wait_cnt == 4'd0) state_nxt = LMR;
        else                  wait_nxt  = wait_cnt - 4'd1;
      end
      LMR: begin
        if (cfg_sdr_tmrd_d < 4'd2) begin
`ifdef SDR_INIT_EXT_MODE_EN
          state_nxt = LEMR;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = WAIT_MRD;
          wait_nxt  = cfg_sdr_tmrd_d - 4'd2;
        end
      end
      WAIT_MRD: begin
        if (wait_cnt == 4'd0) begin
`ifdef SDR_INIT_EXT_MODE_EN
          state_nxt = LEMR;
`else
          state_nxt = DONE;
`endif
        end else begin
          wait_nxt = wait_cnt - 4'd1;
        end
      end
`ifdef SDR_INIT_EXT_MODE_EN
      LEMR: begin
        if (cfg_sdr_tmrd_d < 4'd2) state_nxt = DONE;
        else begin
          state_nxt = WAIT_EMRD;
          wait_nxt  = cfg_sdr_tmrd_d - 4'd2;
        end
      end
      WAIT_EMRD: begin
        if (wait_cnt == 4'd0) state_nxt = DONE;
        else                  wait_nxt  = wait_cnt - 4'd1;
      end
`endif
      DONE: begin
        if (cfg_init_req) begin
          state_nxt = NOP_WAIT;
          nop_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the pins are registered and
  // line up with the state the FSM occupies during that cycle.
  always_comb begin
    cke_nxt  = 1'b1;
    cmd_nxt  = CMD_NOP;
    ba_nxt   = '0;
    addr_nxt = '0;
    done_nxt = 1'b0;
    case (state_nxt)
      IDLE: begin
        cke_nxt = 1'b0;
        cmd_nxt = CMD_DESEL;
      end
      PRE: begin
        cmd_nxt      = CMD_PRE;
        addr_nxt[10] = 1'b1;
      end
      REF1, REF2: cmd_nxt = CMD_REF;
      LMR: begin
        cmd_nxt  = CMD_LMR;
        addr_nxt = cfg_sdr_mode_reg;
      end
`ifdef SDR_INIT_EXT_MODE_EN
      LEMR: begin
        cmd_nxt  = CMD_LMR;
        ba_nxt   = SDR_BA_W'(1);
        addr_nxt = cfg_sdr_ext_mode_reg;
      end
`endif
      DONE: done_nxt = 1'b1;
      default: ;
    endcase
  end

  assign sdr.sdr_cke   = cke_q;
  assign sdr.sdr_cs_n  = cmd_q[3];
  assign sdr.sdr_ras_n = cmd_q[2];
  assign sdr.sdr_cas_n = cmd_q[1];
  assign sdr.sdr_we_n  = cmd_q[0];
  assign sdr.sdr_ba    = ba_q;
  assign sdr.sdr_addr  = addr_q;
  assign init_done     = done_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_sdr_init_seq.sv
// Directed bench for sdr_init_seq: cycle-by-cycle command stream checks against
// hand-computed command cycles (cycle 0 = first cycle after cfg_sdr_en is sampled).
module tb_sdr_init_seq;
  localparam int AW = 13;
  localparam int BW = 2;
  localparam int VW = 1 + 4 + BW + AW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          en = 1'b0;
  logic [AW-1:0] mode_reg = 13'h033;
  logic [AW-1:0] ext_mode_reg = 13'h040;
  logic [3:0]    trp = 4'd2;
  logic [3:0]    trcar = 4'd7;
  logic [3:0]    tmrd = 4'd2;
  logic          init_req = 1'b0;
  logic          init_done;
  logic [3:0]    dbg_state;

  sdr_init_seq_if #(.SDR_ADDR_W(AW), .SDR_BA_W(BW)) sdr_bus ();

  sdr_init_seq dut (
    .sdram_clk            (clk),
    .sdram_resetn         (rst_n),
    .cfg_sdr_en           (en),
    .cfg_sdr_mode_reg     (mode_reg),
`ifdef SDR_INIT_EXT_MODE_EN
    .cfg_sdr_ext_mode_reg (ext_mode_reg),
`endif
    .cfg_sdr_trp_d        (trp),
    .cfg_sdr_trcar_d      (trcar),
    .cfg_sdr_tmrd_d       (tmrd),
    .cfg_init_req         (init_req),
    .sdr                  (sdr_bus),
    .init_done            (init_done),
    .dbg_state            (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [VW-1:0] mk(input logic cke, input logic [3:0] cmd,
                                       input logic [BW-1:0] ba, input logic [AW-1:0] addr,
                                       input logic done);
    return {cke, cmd, ba, addr, done};
  endfunction

  localparam logic [VW-1:0] RST_V = {1'b0, 4'b1111, 2'b00, 13'h0000, 1'b0};

  function automatic logic [VW-1:0] observed();
    return {sdr_bus.sdr_cke, sdr_bus.sdr_cs_n, sdr_bus.sdr_ras_n, sdr_bus.sdr_cas_n,
            sdr_bus.sdr_we_n, sdr_bus.sdr_ba, sdr_bus.sdr_addr, init_done};
  endfunction

  // driver / checker tasks
  task automatic check_vec(input string tag, input int cyc, input logic [VW-1:0] exp_v);
    logic [VW-1:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, exp_v);
    end
  endtask

  // Steps through cycles 0..done_c+1 checking every output vector.
  task automatic run_seq(input string tag, input int pre_c, input int r1_c, input int r2_c,
                         input int lmr_c, input int lemr_c, input int done_c,
                         input int req_at, input int drop_en_at);
    logic [VW-1:0] exp_v;
    for (int c = 0; c <= done_c + 1; c++) begin
      @(posedge clk);
      #1;
      init_req = 1'b0;
      if (c == pre_c)                       exp_v = mk(1'b1, 4'b0010, 2'd0, 13'h400, 1'b0);
      else if (c == r1_c || c == r2_c)      exp_v = mk(1'b1, 4'b0001, 2'd0, 13'h000, 1'b0);
      else if (c == lmr_c)                  exp_v = mk(1'b1, 4'b0000, 2'd0, mode_reg, 1'b0);
      else if (c == lemr_c)                 exp_v = mk(1'b1, 4'b0000, 2'd1, ext_mode_reg, 1'b0);
      else                                  exp_v = mk(1'b1, 4'b0111, 2'd0, 13'h000, c >= done_c);
      check_vec(tag, c, exp_v);
      if (c == req_at)     init_req = 1'b1;
      if (c == drop_en_at) en = 1'b0;
    end
  endtask

  initial begin
    // reset state
    #12;
    check_vec("reset", -1, RST_V);
    checks++;
    assert (dbg_state === 4'd0) else begin
      errors++;
      $error("FAIL reset_state observed %0d expected 0", dbg_state);
    end

    // enable held low after reset release: pins stay idle
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      check_vec("idle_en_low", i, RST_V);
    end

    // default timings; init_req at 300 and enable drop at 200 must be ignored
    en = 1'b1;
`ifdef SDR_INIT_EXT_MODE_EN
    run_seq("seq_default", 500, 502, 509, 516, 518, 520, 300, 200);
`else
    run_seq("seq_default", 500, 502, 509, 516, -1, 518, 300, 200);
`endif

    // re-init request from DONE with a new mode value
    mode_reg = 13'h022;
    init_req = 1'b1;
`ifdef SDR_INIT_EXT_MODE_EN
    run_seq("seq_reinit", 500, 502, 509, 516, 518, 520, -1, -1);
`else
    run_seq("seq_reinit", 500, 502, 509, 516, -1, 518, -1, -1);
`endif

    // zero timing values behave as one cycle
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("reset_before_zero", -1, RST_V);
    trp = 4'd0;
    trcar = 4'd0;
    tmrd = 4'd0;
    mode_reg = 13'h031;
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef SDR_INIT_EXT_MODE_EN
    run_seq("seq_zero", 500, 501, 502, 503, 504, 505, -1, -1);
`else
    run_seq("seq_zero", 500, 501, 502, 503, -1, 504, -1, -1);
`endif

    // asynchronous reset mid-cycle returns pins to reset values at once
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("async_reset", -1, RST_V);
    trp = 4'd2;
    trcar = 4'd7;
    tmrd = 4'd2;
    mode_reg = 13'h033;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef SDR_INIT_EXT_MODE_EN
    run_seq("seq_after_reset", 500, 502, 509, 516, 518, 520, -1, -1);
`else
    run_seq("seq_after_reset", 500, 502, 509, 516, -1, 518, -1, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
